// File: rtl/mem_port_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared params for the memory port arbiter    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEF      = 255;
    localparam int DATA_RUN_MAX_DEF = 2;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
// +--------------------------------------------------------------------+
// | mem_watchdog : counts enabled cycles, flags expiry at the limit     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expires on the limit-th enabled cycle; a zero limit never expires.
    assign expired_o = enable_i &&
                       (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, limit_i});

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int DATA_RUN_MAX = DATA_RUN_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);

    localparam int WD_W  = cnt_width(TIMEOUT);
    localparam int RUN_W = cnt_width(DATA_RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DATA_RUN_MAX);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic [RUN_W-1:0]  data_run_q, data_run_d;

    logic              wd_expired;
    logic              grant_data;
    logic              grant_fetch;
    logic              txn_done;
    logic [DATA_W-1:0] txn_rdata;

    mem_watchdog #(
        .CNT_W (WD_W)
    ) u_watchdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable_i  (mem_req_q & ~mem_ack),
        .clear_i   (~mem_req_q),
        .limit_i   (WD_W'(TIMEOUT)),
        .expired_o (wd_expired)
    );

    // Data normally wins; a waiting fetch wins once data has had its run.
    assign grant_data  = (state_q == ST_IDLE) && d_req &&
                         !(if_req && (data_run_q == RUN_MAX));
    assign grant_fetch = (state_q == ST_IDLE) && if_req && !grant_data;

    // An ack that races the watchdog still delivers real data.
    assign txn_done  = mem_ack | wd_expired;
    assign txn_rdata = mem_ack ? mem_rdata : '0;

    always_comb begin
        data_run_d = data_run_q;
        if (!if_req || grant_fetch) begin
            data_run_d = '0;
        end else if (grant_data && (data_run_q != RUN_MAX)) begin
            data_run_d = data_run_q + RUN_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_data_d     = if_data_q;
        d_rdata_d     = d_rdata_q;
        if_valid_d    = 1'b0;
        d_valid_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_fetch) begin
                    state_d     = ST_FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (txn_done) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_ack) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == ST_DATA) begin
                        d_rdata_d = txn_rdata;
                        d_valid_d = 1'b1;
                    end else if (if_req) begin
                        // A dropped if_req means the fetch was flushed.
                        if_data_d  = txn_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_data_q     <= '0;
            d_rdata_q     <= '0;
            if_valid_q    <= 1'b0;
            d_valid_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            data_run_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_data_q     <= if_data_d;
            d_rdata_q     <= d_rdata_d;
            if_valid_q    <= if_valid_d;
            d_valid_q     <= d_valid_d;
            timeout_err_q <= timeout_err_d;
            data_run_q    <= data_run_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_data     = if_data_q;
    assign d_rdata     = d_rdata_q;
    assign if_valid    = if_valid_q;
    assign d_valid     = d_valid_q;
    assign timeout_err = timeout_err_q;

    assign stall_mem = d_req & ~d_valid_q;
    assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for the arbiter  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_if_data;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_data     (if_data),
        .if_valid    (if_valid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_vec++;
        if ({mem_req, mem_we, if_valid, d_valid, timeout_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b expected 00000",
                              {mem_req, mem_we, if_valid, d_valid, timeout_err});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, if_data, d_rdata} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0",
                              {mem_addr, mem_wdata, if_data, d_rdata});
        end
        d_req = 1'b1; #1;
        n_vec++;
        if ({stall_mem, stall_if} !== 2'b11) begin
            n_err++; $display("FAIL reset_stall_d: got %b expected 11", {stall_mem, stall_if});
        end
        d_req = 1'b0; if_req = 1'b1; #1;
        n_vec++;
        if ({stall_mem, stall_if} !== 2'b01) begin
            n_err++; $display("FAIL reset_stall_if: got %b expected 01", {stall_mem, stall_if});
        end
        if_req = 1'b0;
        reset_n = 1'b1;
        tick();
        exp_if_data = '0; exp_d_rdata = '0;
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0040_0000; #1;
        n_vec++;
        if (stall_if !== 1'b1) begin
            n_err++; $display("FAIL fetch_stall_c0: got %b expected 1", stall_if);
        end
        tick();
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0040_0000}) begin
                n_err++; $display("FAIL fetch_bus c%0d: got %b %b %h expected 1 0 00400000",
                                  c, mem_req, mem_we, mem_addr);
            end
            n_vec++;
            if ({stall_if, if_valid} !== 2'b10) begin
                n_err++; $display("FAIL fetch_wait c%0d: got %b expected 10", c, {stall_if, if_valid});
            end
            if (c == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'h0000_0033;
            end
            tick();
        end
        mem_ack = 1'b0;
        n_vec++;
        if ({if_valid, if_data, stall_if, mem_req} !== {1'b1, 32'h0000_0033, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL fetch_done: got %b %h %b %b expected 1 00000033 0 0",
                              if_valid, if_data, stall_if, mem_req);
        end
        if_req = 1'b0;
        tick();
        n_vec++;
        if ({if_valid, if_data, mem_req} !== {1'b0, 32'h0000_0033, 1'b0}) begin
            n_err++; $display("FAIL fetch_after: got %b %h %b expected 0 00000033 0",
                              if_valid, if_data, mem_req);
        end
        exp_if_data = 32'h0000_0033;
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h0040_0004;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
        tick();
        n_vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL simul_data_bus: got %b %b %h %h expected 1 1 10010000 deadbeef",
                              mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({d_valid, if_valid, stall_mem, stall_if} !== 4'b1001) begin
            n_err++; $display("FAIL simul_dvalid: got %b expected 1001",
                              {d_valid, if_valid, stall_mem, stall_if});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        n_vec++;
        if ({mem_req, mem_we, mem_addr, d_valid} !== {1'b1, 1'b0, 32'h0040_0004, 1'b0}) begin
            n_err++; $display("FAIL simul_fetch_bus: got %b %b %h %b expected 1 0 00400004 0",
                              mem_req, mem_we, mem_addr, d_valid);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({if_valid, if_data} !== {1'b1, 32'h0000_0013}) begin
            n_err++; $display("FAIL simul_fetch_done: got %b %h expected 1 00000013", if_valid, if_data);
        end
        if_req = 1'b0;
        tick();
        exp_if_data = 32'h0000_0013; exp_d_rdata = 32'h0000_0001;
    endtask

    task automatic test_starvation();
        logic        is_f;
        logic [31:0] exp_addr;
        logic [31:0] got_data;
        if_req = 1'b1; if_addr = 32'h0040_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040;
        tick();
        for (int g = 0; g < 5; g++) begin
            is_f     = (g == 2);
            exp_addr = is_f ? 32'h0040_0100 : 32'h1001_0040;
            n_vec++;
            if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
                n_err++; $display("FAIL starve_grant%0d: got %b %h expected 1 %h",
                                  g, mem_req, mem_addr, exp_addr);
            end
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(g);
            tick();
            mem_ack = 1'b0;
            got_data = is_f ? if_data : d_rdata;
            n_vec++;
            if ({if_valid, d_valid, got_data} !== {is_f, ~is_f, 32'hA000_0000 + 32'(g)}) begin
                n_err++; $display("FAIL starve_valid%0d: got %b %b %h expected %b %b %h",
                                  g, if_valid, d_valid, got_data, is_f, ~is_f, 32'hA000_0000 + 32'(g));
            end
            if (g == 4) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            tick();
        end
        n_vec++;
        if (mem_req !== 1'b0) begin
            n_err++; $display("FAIL starve_idle: got %b expected 0", mem_req);
        end
        exp_if_data = 32'hA000_0002; exp_d_rdata = 32'hA000_0004;
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h0040_0200;
        tick();
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0040_0200}) begin
            n_err++; $display("FAIL flush_grant: got %b %h expected 1 00400200", mem_req, mem_addr);
        end
        if_req = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({mem_req, if_valid} !== 2'b10) begin
            n_err++; $display("FAIL flush_persist: got %b expected 10", {mem_req, if_valid});
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({if_valid, mem_req, if_data} !== {1'b0, 1'b0, exp_if_data}) begin
            n_err++; $display("FAIL flush_suppress: got %b %b %h expected 0 0 %h",
                              if_valid, mem_req, if_data, exp_if_data);
        end
        tick();
        n_vec++;
        if ({if_valid, mem_req} !== 2'b00) begin
            n_err++; $display("FAIL flush_idle: got %b expected 00", {if_valid, mem_req});
        end
    endtask

    task automatic test_timeout();
        int   n_wait;
        logic got;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0080;
        tick();
        n_wait = 0; got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            if (d_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                tick();
                n_wait++;
            end
        end
        n_vec++;
        if (!got || n_wait != 255) begin
            n_err++; $display("FAIL timeout_latency: got %0d cycles (seen=%b) expected 255", n_wait, got);
        end
        n_vec++;
        if ({d_rdata, timeout_err, mem_req} !== {32'h0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL timeout_result: got %h %b %b expected 00000000 1 0",
                              d_rdata, timeout_err, mem_req);
        end
        d_req = 1'b0;
        tick();
        n_vec++;
        if ({d_valid, timeout_err} !== 2'b01) begin
            n_err++; $display("FAIL timeout_sticky: got %b expected 01", {d_valid, timeout_err});
        end
        if_req = 1'b1; if_addr = 32'h0040_0300;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({if_valid, if_data, timeout_err} !== {1'b1, 32'h0000_0055, 1'b1}) begin
            n_err++; $display("FAIL timeout_fetch: got %b %h %b expected 1 00000055 1",
                              if_valid, if_data, timeout_err);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_data();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0100; d_wdata = 32'h1234_5678;
        tick();
        n_vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h1001_0100, 32'h1234_5678}) begin
            n_err++; $display("FAIL rst_mid_bus: got %b %b %h %h expected 1 1 10010100 12345678",
                              mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        reset_n = 1'b0; #1;
        n_vec++;
        if ({mem_req, mem_we, if_valid, d_valid, timeout_err, mem_addr, mem_wdata, if_data, d_rdata}
            !== 133'h0) begin
            n_err++; $display("FAIL rst_mid_clear: got %b%b%b%b%b %h %h %h %h expected all 0",
                              mem_req, mem_we, if_valid, d_valid, timeout_err,
                              mem_addr, mem_wdata, if_data, d_rdata);
        end
        n_vec++;
        if ({stall_mem, stall_if} !== 2'b11) begin
            n_err++; $display("FAIL rst_mid_stall: got %b expected 11", {stall_mem, stall_if});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({mem_req, if_valid, d_valid, timeout_err, d_rdata, if_data} !== 68'h0) begin
            n_err++; $display("FAIL rst_late_ack: got %b%b%b%b %h %h expected all 0",
                              mem_req, if_valid, d_valid, timeout_err, d_rdata, if_data);
        end
        if_req = 1'b1; if_addr = 32'h0040_0400;
        tick();
        n_vec++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0040_0400}) begin
            n_err++; $display("FAIL rst_idle_grant: got %b %b %h expected 1 0 00400400",
                              mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if ({if_valid, if_data} !== {1'b1, 32'h0000_0099}) begin
            n_err++; $display("FAIL rst_idle_fetch: got %b %h expected 1 00000099", if_valid, if_data);
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_timeout();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
